mono_video_shaper: RTL
======================

# mono_video_shaper

Parametrised monochrome video back-end for single-colour arcade cores. It generates the pixel clock enable and maps an N-bit video level through a runtime-writable palette into RGB. Four tint modes are supported. The block also measures active picture geometry for scaler/aspect setup. It sits between a core's raw video/blank/sync outputs and the arcade_video scaler path, replacing a hard-coded mono case table and free-running ce divider.

## Interface
Parameters:
- LEVEL_BITS, 2, width of the core video level input; the palette has 2^LEVEL_BITS entries.
- OUT_BITS, 3, width of each RGB component and of each palette entry.
- CE_DIV, 8, clk_sys cycles per pixel. Must be ≥2.

Ports:
- clk_sys  in  1  system/video clock; the only clock.
- Reset_I  in  1  synchronous, active-low reset.
- mode  in  2  tint: 0 grey, 1 green, 2 amber, 3 inverted grey.
- vid_in  in  LEVEL_BITS  core video level.
- hblank_in, vblank_in, hs_in, vs_in  in  1 each  core timing, active high.
- pal_we  in  1  palette write strobe.
- pal_addr  in  LEVEL_BITS  palette index.
- pal_data  in  OUT_BITS  palette value.
- ce_pix  out  1  pixel enable: one clk_sys cycle high per CE_DIV.
- r, g, b  out  OUT_BITS each  shaped colour.
- hblank, vblank, hs, vs  out  1 each  timing aligned with r/g/b.
- act_width, act_height  out  12 each  measured active pixels/line and lines/frame.
- geom_valid  out  1  high once one complete frame has been measured.

## Operation
- Divider: counter div runs 0..CE_DIV-1 and wraps. ce_pix is registered and high in the cycle after div==CE_DIV-1, which makes the period exactly CE_DIV.
- Sample edge: the clk_sys edge where ce_pix==1. All datapath and geometry state changes only on sample edges, except palette writes.
- Palette: pal[i] is written on any edge with pal_we=1. Reset value is pal[i] = floor(i*(2^OUT_BITS-1)/(2^LEVEL_BITS-1)). For LEVEL_BITS=2 and OUT_BITS=3 this gives 0,2,4,7.
- Lookup: L = pal[vid_in]. For OUT_BITS=3, M = 7.
  - grey: r=g=b=L.
  - green: r=0, g=L, b=0.
  - amber: r=L, g=L>>1, b=0.
  - inverted: r=g=b=M-L, where M=2^OUT_BITS-1.
- Blanking: if hblank_in|vblank_in is high at the sample edge, r=g=b=0 regardless of mode.
- Timing passthrough: hblank, vblank, hs and vs are registered on the same sample edge as r/g/b, so alignment is exact.
- Geometry counters (sample edges only; ph/pv are previously sampled hblank_in/vblank_in):
  - active sample (both blanks low): pix_cnt++, saturating at 4095.
  - hblank rise (hblank_in & ~ph): if pix_cnt≠0 then line_w←pix_cnt and line_cnt++ (saturating at 4095). pix_cnt←0 in either case.
  - vblank rise (vblank_in & ~pv): if line_cnt≠0 then act_width←line_w, act_height←line_cnt and geom_valid←1. line_cnt←0.
  - hblank and vblank rise on the same edge: the line is counted first, so the frame latch includes it.

## Timing
- Reset (Reset_I=0 at an edge) sets:
  - div=0, ce_pix=0.
  - r/g/b=0, hs=vs=0, hblank=vblank=1.
  - pix_cnt, line_cnt, line_w, act_width, act_height = 0; geom_valid=0.
  - ph=pv=1, so a blank already high at reset is not treated as a rise.
  - palette reloads its ramp.
- First ce_pix pulse after release: CE_DIV cycles after the first edge with Reset_I=1.
- Reset mid-frame discards partial counts. geom_valid stays 0 until the next complete frame, i.e. the second vblank rise after reset.
- Latency: inputs sampled at edge k appear on the outputs after edge k. Outputs hold for CE_DIV cycles.
- Palette write and lookup of the same index on the same edge: lookup uses the old value (read-before-write). The new value is seen at the next sample edge.
- A mode change takes effect at the next sample edge. There is no glitch between sample edges.
- All arithmetic is unsigned. Saturation at 4095 holds; counters never wrap.

## Structure
- Shared package mono_video_pkg:
  - tint_e enum (TINT_GREY, TINT_GREEN, TINT_AMBER, TINT_INV).
  - GEOM_BITS=12.
  - GEOM_MAX=4095.
- One sub-module, mono_geom_meter: holds the pix/line/frame counters, the edge detectors and the latched geometry outputs. Its inputs are ce_pix, hblank_in and vblank_in.
- Divider, palette RAM, tint mux and output registers stay in the top level.

## Test plan
- Reset then idle, CE_DIV=8 → ce_pix first high 8 cycles after release, then every 8 cycles. Outputs hold their reset values until that first pulse.
- Default palette, grey mode, vid_in 0,1,2,3 unblanked → r=g=b = 0,2,4,7, one sample edge later. With hblank_in=1 → all 0.
- Write pal[3]=5 on the same edge as a sample with vid_in=3 → that sample gives 7, next gives 5. In amber mode → r=5, g=2, b=0. In inverted mode with L=2 → 5.
- Synthetic frame of 256 active pixels × 224 lines → after the second vblank rise, act_width=256, act_height=224, geom_valid=1. A frame with 5000 active pixels/line → act_width=4095.
- Reset asserted mid-frame then released → geom_valid=0 through the next vblank rise. Correct values appear after the following frame. hblank and vblank rising on the same edge count the final line.

Source files
------------

// File: rtl/mono_video_pkg.sv
// rtl/mono_video_pkg.sv - shared types, geometry limits and helpers for the mono video shaper
package mono_video_pkg;

  typedef enum logic [1:0] {
    TINT_GREY  = 2'd0,
    TINT_GREEN = 2'd1,
    TINT_AMBER = 2'd2,
    TINT_INV   = 2'd3
  } tint_e;

  localparam int GEOM_BITS = 12;
  localparam logic [GEOM_BITS-1:0] GEOM_MAX = 12'd4095;

  // Default palette entry: linear ramp from 0 to full scale.
  function automatic int ramp_level(input int idx, input int level_bits, input int out_bits);
    return (idx * ((1 << out_bits) - 1)) / ((1 << level_bits) - 1);
  endfunction

  function automatic logic [GEOM_BITS-1:0] sat_inc(input logic [GEOM_BITS-1:0] val);
    return (val == GEOM_MAX) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/mono_geom_meter.sv
// rtl/mono_geom_meter.sv - measures active pixels/line and lines/frame from blanking
module mono_geom_meter
  import mono_video_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_resetn,
  input  logic                 i_ce,
  input  logic                 i_hblank,
  input  logic                 i_vblank,
  output logic [GEOM_BITS-1:0] o_width,
  output logic [GEOM_BITS-1:0] o_height,
  output logic                 o_valid
);

  logic [GEOM_BITS-1:0] r_pix;
  logic [GEOM_BITS-1:0] r_line;
  logic [GEOM_BITS-1:0] r_line_w;
  logic [GEOM_BITS-1:0] r_width;
  logic [GEOM_BITS-1:0] r_height;
  logic                 r_ph;
  logic                 r_pv;
  logic                 r_armed;
  logic                 r_valid;

  logic                 w_hrise;
  logic                 w_vrise;
  logic                 w_active;
  logic                 w_line_done;
  logic [GEOM_BITS-1:0] w_line_cnt;
  logic [GEOM_BITS-1:0] w_line_w;

  assign w_hrise     = i_hblank & ~r_ph;
  assign w_vrise     = i_vblank & ~r_pv;
  assign w_active    = ~i_hblank & ~i_vblank;
  assign w_line_done = w_hrise && (r_pix != '0);
  // Line closed on this edge is folded in before a same-edge frame latch.
  assign w_line_cnt  = w_line_done ? sat_inc(r_line) : r_line;
  assign w_line_w    = w_line_done ? r_pix : r_line_w;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_pix    <= '0;
      r_line   <= '0;
      r_line_w <= '0;
      r_width  <= '0;
      r_height <= '0;
      r_ph     <= 1'b1;
      r_pv     <= 1'b1;
      r_armed  <= 1'b0;
      r_valid  <= 1'b0;
    end else if (i_ce) begin
      r_ph     <= i_hblank;
      r_pv     <= i_vblank;
      r_line_w <= w_line_w;
      if (w_active) begin
        r_pix <= sat_inc(r_pix);
      end else if (w_hrise) begin
        r_pix <= '0;
      end
      // First frame boundary after reset only arms: the frame before it may be partial.
      if (w_vrise) begin
        r_line  <= '0;
        r_armed <= 1'b1;
        if (r_armed && (w_line_cnt != '0)) begin
          r_width  <= w_line_w;
          r_height <= w_line_cnt;
          r_valid  <= 1'b1;
        end
      end else begin
        r_line <= w_line_cnt;
      end
    end
  end

  assign o_width  = r_width;
  assign o_height = r_height;
  assign o_valid  = r_valid;

endmodule

// File: rtl/mono_video_shaper.sv
// rtl/mono_video_shaper.sv - pixel enable, palette lookup, tint and blanking for mono video
module mono_video_shaper
  import mono_video_pkg::*;
#(
  parameter int LEVEL_BITS = 2,
  parameter int OUT_BITS   = 3,
  parameter int CE_DIV     = 8
) (
  input  logic                  clk_sys,
  input  logic                  Reset_I,
  input  logic [1:0]            mode,
  input  logic [LEVEL_BITS-1:0] vid_in,
  input  logic                  hblank_in,
  input  logic                  vblank_in,
  input  logic                  hs_in,
  input  logic                  vs_in,
  input  logic                  pal_we,
  input  logic [LEVEL_BITS-1:0] pal_addr,
  input  logic [OUT_BITS-1:0]   pal_data,
  output logic                  ce_pix,
  output logic [OUT_BITS-1:0]   r,
  output logic [OUT_BITS-1:0]   g,
  output logic [OUT_BITS-1:0]   b,
  output logic                  hblank,
  output logic                  vblank,
  output logic                  hs,
  output logic                  vs,
  output logic [11:0]           act_width,
  output logic [11:0]           act_height,
  output logic                  geom_valid
);

  localparam int PAL_N = 1 << LEVEL_BITS;
  localparam int DIV_W = $clog2(CE_DIV);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CE_DIV - 1);
  localparam logic [OUT_BITS-1:0] LVL_MAX  = '1;

  logic [DIV_W-1:0]    r_div;
  logic                r_ce;
  logic [OUT_BITS-1:0] r_pal [PAL_N];
  logic [OUT_BITS-1:0] r_r, r_g, r_b;
  logic                r_hblank, r_vblank, r_hs, r_vs;

  logic [OUT_BITS-1:0] w_level;
  logic [OUT_BITS-1:0] w_r, w_g, w_b;

  always_ff @(posedge clk_sys) begin
    if (!Reset_I) begin
      r_div <= '0;
      r_ce  <= 1'b0;
    end else begin
      r_ce  <= (r_div == DIV_LAST);
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    end
  end

  // Writes land on any edge; lookups read the pre-write value.
  always_ff @(posedge clk_sys) begin
    if (!Reset_I) begin
      for (int i = 0; i < PAL_N; i++) begin
        r_pal[i] <= OUT_BITS'(ramp_level(i, LEVEL_BITS, OUT_BITS));
      end
    end else if (pal_we) begin
      r_pal[pal_addr] <= pal_data;
    end
  end

  assign w_level = r_pal[vid_in];

  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    if (!(hblank_in | vblank_in)) begin
      case (tint_e'(mode))
        TINT_GREY:  begin w_r = w_level; w_g = w_level; w_b = w_level; end
        TINT_GREEN: begin w_g = w_level; end
        TINT_AMBER: begin w_r = w_level; w_g = w_level >> 1; end
        TINT_INV:   begin
          w_r = LVL_MAX - w_level;
          w_g = LVL_MAX - w_level;
          w_b = LVL_MAX - w_level;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!Reset_I) begin
      r_r      <= '0;
      r_g      <= '0;
      r_b      <= '0;
      r_hblank <= 1'b1;
      r_vblank <= 1'b1;
      r_hs     <= 1'b0;
      r_vs     <= 1'b0;
    end else if (r_ce) begin
      r_r      <= w_r;
      r_g      <= w_g;
      r_b      <= w_b;
      r_hblank <= hblank_in;
      r_vblank <= vblank_in;
      r_hs     <= hs_in;
      r_vs     <= vs_in;
    end
  end

  mono_geom_meter u_geom (
    .i_clk    (clk_sys),
    .i_resetn (Reset_I),
    .i_ce     (r_ce),
    .i_hblank (hblank_in),
    .i_vblank (vblank_in),
    .o_width  (act_width),
    .o_height (act_height),
    .o_valid  (geom_valid)
  );

  assign ce_pix = r_ce;
  assign r      = r_r;
  assign g      = r_g;
  assign b      = r_b;
  assign hblank = r_hblank;
  assign vblank = r_vblank;
  assign hs     = r_hs;
  assign vs     = r_vs;

endmodule
